// File: rtl/nv_nvdla_cdp_dp_rdma_ingress.sv
// CDP RDMA ingress: accepts read-DMA beats for one layer, tags each beat with
// line/surface/layer end flags from the latched cube geometry, and buffers
// them in a 2-entry FIFO toward the CDP datapath.
//
// state | meaning
// IDLE  | waiting for reg2dp_op_en; input not ready
// RUN   | accepting beats and advancing the w/h/s position counters
// DRAIN | layer_end beat accepted; waiting for the FIFO to empty
module nv_nvdla_cdp_dp_rdma_ingress #(
    parameter int DATA_W = 64
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              reg2dp_op_en,
    input  logic [12:0]       reg2dp_width,
    input  logic [12:0]       reg2dp_height,
    input  logic [12:0]       reg2dp_channel,
    input  logic              cdp_rdma2dp_valid,
    output logic              cdp_rdma2dp_ready,
    input  logic [86:0]       cdp_rdma2dp_pd,
    output logic              dp_in_valid,
    input  logic              dp_in_ready,
    output logic [DATA_W+2:0] dp_in_pd,
    output logic              dp2reg_done,
    output logic              dp2reg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [12:0]       width_q, width_d;
    logic [12:0]       height_q, height_d;
    logic [9:0]        surf_q, surf_d;
    logic [12:0]       w_cnt_q, w_cnt_d;
    logic [12:0]       h_cnt_q, h_cnt_d;
    logic [9:0]        s_cnt_q, s_cnt_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W+2:0] mem_q [2];
    logic [DATA_W+2:0] mem_d [2];
    logic              err_q, err_d;

    logic start;
    logic push;
    logic pop;
    logic line_end;
    logic surf_end;
    logic layer_end;
    logic unused_inputs;

    // Upper payload bits and the sub-surface channel bits carry no meaning here.
    assign unused_inputs = ^{cdp_rdma2dp_pd[86:DATA_W], reg2dp_channel[2:0]};

    // FSM state register.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; op_en is only sampled in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (reg2dp_op_en) state_d = ST_RUN;
            ST_RUN:   if (push && layer_end) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == 2'd0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; input ready looks only at registered occupancy.
    always_comb begin
        start             = (state_q == ST_IDLE) && reg2dp_op_en;
        cdp_rdma2dp_ready = (state_q == ST_RUN) && (cnt_q != 2'd2);
        dp2reg_done       = (state_q == ST_DRAIN) && (cnt_q == 2'd0);
    end

    assign push        = cdp_rdma2dp_valid && cdp_rdma2dp_ready;
    assign dp_in_valid = (cnt_q != 2'd0);
    assign dp_in_pd    = mem_q[rd_ptr_q];
    assign pop         = dp_in_valid && dp_in_ready;
    assign dp2reg_err  = err_q;

    // Position flags for the beat being accepted, from shadow geometry only.
    always_comb begin
        line_end  = (w_cnt_q == width_q);
        surf_end  = line_end && (h_cnt_q == height_q);
        layer_end = surf_end && (s_cnt_q == surf_q);
    end

    // Shadow geometry, position counters and protocol-error flag.
    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        surf_d   = surf_q;
        w_cnt_d  = w_cnt_q;
        h_cnt_d  = h_cnt_q;
        s_cnt_d  = s_cnt_q;
        err_d    = err_q;
        if (start) begin
            width_d  = reg2dp_width;
            height_d = reg2dp_height;
            surf_d   = reg2dp_channel[12:3];
            w_cnt_d  = '0;
            h_cnt_d  = '0;
            s_cnt_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (cdp_rdma2dp_valid && (state_q != ST_RUN)) begin
                err_d = 1'b1;
            end
            if (push) begin
                if (layer_end) begin
                    w_cnt_d = '0;
                    h_cnt_d = '0;
                    s_cnt_d = '0;
                end else if (surf_end) begin
                    w_cnt_d = '0;
                    h_cnt_d = '0;
                    s_cnt_d = s_cnt_q + 10'd1;
                end else if (line_end) begin
                    w_cnt_d = '0;
                    h_cnt_d = h_cnt_q + 13'd1;
                end else begin
                    w_cnt_d = w_cnt_q + 13'd1;
                end
            end
        end
    end

    // Two-entry FIFO bookkeeping; the beat is stored together with its flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {layer_end, surf_end, line_end, cdp_rdma2dp_pd[DATA_W-1:0]};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            width_q  <= '0;
            height_q <= '0;
            surf_q   <= '0;
            w_cnt_q  <= '0;
            h_cnt_q  <= '0;
            s_cnt_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            width_q  <= width_d;
            height_q <= height_d;
            surf_q   <= surf_d;
            w_cnt_q  <= w_cnt_d;
            h_cnt_q  <= h_cnt_d;
            s_cnt_q  <= s_cnt_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

endmodule
